lfsr_rand_server: RTL and testbench
===================================

Name: lfsr_rand_server

Overview:
Controller that sequences the 26-bit LFSR and shares its output between two requesters.
- Drives the LFSR seed-load interface and owns the LFSR reset.
- Enforces a warm-up period after every seed.
- Detects the all-zero lock-up state and reseeds.
- Serves random words to two clients through a round-robin grant.
- Sits between the LFSR instance and its consumers; the LFSR has no enable and steps every clk.

Parameters:
- DEFAULT_SEED, 26'h0000001, seed used at reset, on zero lock-up, and whenever a requested seed is zero.
- WARMUP, 8, LFSR steps after a load before words are served (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_req  in  1  one-cycle pulse: reseed the LFSR with seed_val.
- seed_val  in  26  requested seed, indexed [1:26].
- req  in  2  level requests from client 0 / client 1.
- gnt  out  2  one-hot grant pulse, one cycle per word.
- rdata  out  26  random word, valid while any gnt bit is high.
- ready  out  1  high only in RUN (words are being served).
- zero_cnt  out  8  saturating count of zero lock-up events.
- lfsr_rst_n  out  1  LFSR reset; combinational ~rst.
- lfsr_load  out  1  LFSR load strobe.
- lfsr_din  out  26  LFSR parallel seed, indexed [1:26].
- lfsr_q  in  26  LFSR state, indexed [1:26].

Behaviour:
- All outputs are registered except lfsr_rst_n.
- Reset values: gnt=0, rdata=0, ready=0, zero_cnt=0, lfsr_load=0, lfsr_din=0. State=LOAD, pending seed=DEFAULT_SEED, rr pointer=client 0, warm counter=0.
- States: LOAD, WARM, RUN.
- LOAD:
  - lfsr_load=1 and lfsr_din=pending seed for exactly one cycle.
  - Next state is WARM with the counter cleared.
  - First LOAD cycle begins at the first rising edge with rst=0.
- WARM:
  - lfsr_load=0 and lfsr_din=0.
  - Counter increments each cycle; on reaching WARMUP-1, go to RUN.
  - ready rises at the edge after the last WARM cycle, so first ready is WARMUP+1 cycles after the load strobe.
- RUN:
  - If req≠0 is sampled at an edge, the following cycle has one gnt bit high and rdata = lfsr_q sampled at that same edge.
  - At most one grant per cycle.
  - Round-robin: the client granted last has lower priority; a lone requester is granted every cycle.
  - Continuous req yields back-to-back grants, alternating when both are held.
  - Each grant carries a different LFSR step.
  - Clients drop req the cycle they see gnt, unless they want another word.
- Zero lock-up: lfsr_q==0 sampled in RUN or WARM means:
  - no grant that cycle;
  - zero_cnt increments, saturating at 255;
  - pending seed becomes DEFAULT_SEED and the next state is LOAD;
  - ready drops at the same edge.
- seed_req is accepted in any state:
  - pending seed becomes seed_val, or DEFAULT_SEED if seed_val==0;
  - the next state is LOAD; ready drops and no grant is issued that cycle.
  - If seed_req arrives during WARM, warm-up restarts from the new load.
  - If seed_req arrives during LOAD, the strobe in progress completes and a second LOAD follows with the new seed.
- Simultaneous events:
  - seed_req and zero detect in the same cycle: seed_req wins and zero_cnt still increments.
  - seed_req and req in the same cycle: no grant; the request is served after re-entry to RUN.
- rst asserted mid-operation: at the next edge all registers take reset values; any grant in flight is dropped.
- rdata holds its last value when gnt=0; consumers must not use it then.

Test Plan:
- Reset 3 cycles, release, no req → lfsr_load=1 for exactly 1 cycle with lfsr_din=26'h0000001; ready=1 exactly 9 cycles after the load cycle; gnt stays 0.
- In RUN, hold req=2'b11 for 6 cycles → gnt sequence 01,10,01,10,01,10; each rdata equals lfsr_q of the preceding cycle and all six are distinct.
- In RUN, hold req=2'b10 for 4 cycles → gnt=10 on 4 consecutive cycles; gnt[0] never asserts.
- Pulse seed_req with seed_val=26'h2AAAAAA while req=2'b01 → no gnt that cycle; ready=0; lfsr_din=26'h2AAAAAA on the next load strobe; grants resume WARMUP+1 cycles later.
- Pulse seed_req with seed_val=0 → lfsr_din=26'h0000001. Separately, force lfsr_q=0 in RUN → zero_cnt=1, reload with DEFAULT_SEED, no grant that cycle.
- Assert rst for 1 cycle while both req are high in RUN → gnt=0, ready=0, zero_cnt=0 after the edge; LOAD restarts on release.

Source files
------------

// File: rtl/lfsr_rand_server.sv
// lfsr_rand_server: seeds, warms up and watches a free-running 26-bit LFSR, and shares its words
// between two clients through a round-robin grant.
module lfsr_rand_server #(
    parameter logic [1:26] DEFAULT_SEED = 26'h0000001,
    parameter int          WARMUP       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_req,
    input  logic [1:26] seed_val,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [25:0] rdata,
    output logic        ready,
    output logic [7:0]  zero_cnt,
    output logic        lfsr_rst_n,
    output logic        lfsr_load,
    output logic [1:26] lfsr_din,
    input  logic [1:26] lfsr_q
);
    typedef enum logic [1:0] {LOAD, WARM, RUN} state_t;
    localparam logic [7:0] LAST = 8'(WARMUP - 1);
    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx, zero_cnt_nx;
    logic [1:26] pend, pend_nx, din_nx;
    logic [1:0]  gnt_nx;
    logic [25:0] rdata_nx;
    logic        prio, prio_nx, ready_nx, load_nx, zero, serve, pick;
    assign lfsr_rst_n = ~rst;
    always_comb begin
        // while the strobe is visible the LFSR still holds its pre-load value
        zero        = state != LOAD && !lfsr_load && lfsr_q == '0;
        serve       = state == RUN && !zero && !seed_req && req != 2'b00;
        pick        = (req == 2'b11) ? prio : req[1];
        state_nx    = state;
        cnt_nx      = cnt + 8'd1;
        pend_nx     = pend;
        prio_nx     = serve ? ~pick : prio;
        gnt_nx      = serve ? (pick ? 2'b10 : 2'b01) : 2'b00;
        rdata_nx    = serve ? lfsr_q : rdata;
        ready_nx    = state == RUN && !zero && !seed_req;
        zero_cnt_nx = zero_cnt + 8'(zero && zero_cnt != 8'hff);
        load_nx     = state == LOAD;
        din_nx      = (state == LOAD) ? pend : '0;
        case (state)
            LOAD: begin
                state_nx = WARM;
                cnt_nx   = '0;
            end
            WARM:    state_nx = (cnt == LAST) ? RUN : WARM;
            default: state_nx = state;
        endcase
        if (zero) begin
            pend_nx  = DEFAULT_SEED;
            state_nx = LOAD;
        end
        if (seed_req) begin
            pend_nx  = (seed_val == '0) ? DEFAULT_SEED : seed_val;
            state_nx = LOAD;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            pend      <= DEFAULT_SEED;
            prio      <= 1'b0;
            gnt       <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            zero_cnt  <= '0;
            lfsr_load <= 1'b0;
            lfsr_din  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pend      <= pend_nx;
            prio      <= prio_nx;
            gnt       <= gnt_nx;
            rdata     <= rdata_nx;
            ready     <= ready_nx;
            zero_cnt  <= zero_cnt_nx;
            lfsr_load <= load_nx;
            lfsr_din  <= din_nx;
        end
    end
endmodule

// File: tb/tb_lfsr_rand_server.sv
// tb_lfsr_rand_server: table, hand-written and random checks of lfsr_rand_server against a
// behavioural LFSR and round-robin model.
module tb_lfsr_rand_server;
    logic        clk = 1'b0, rst = 1'b1, seed_req = 1'b0, force_zero = 1'b0;
    logic [1:26] seed_val = '0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic [25:0] rdata;
    logic        ready, lfsr_rst_n, lfsr_load;
    logic [7:0]  zero_cnt;
    logic [1:26] lfsr_din, lfsr_q, lfsr_reg;
    int          n_chk = 0, n_pass = 0;

    lfsr_rand_server dut (
        .clk(clk), .rst(rst), .seed_req(seed_req), .seed_val(seed_val), .req(req),
        .gnt(gnt), .rdata(rdata), .ready(ready), .zero_cnt(zero_cnt),
        .lfsr_rst_n(lfsr_rst_n), .lfsr_load(lfsr_load), .lfsr_din(lfsr_din), .lfsr_q(lfsr_q)
    );

    always #5 clk = ~clk;

    // behavioural LFSR the controller sits in front of; force_zero fakes a lock-up
    always @(posedge clk)
        if (!lfsr_rst_n) lfsr_reg <= 26'h1;
        else if (lfsr_load) lfsr_reg <= lfsr_din;
        else lfsr_reg <= {lfsr_reg[26] ^ lfsr_reg[25] ^ lfsr_reg[24] ^ lfsr_reg[20], lfsr_reg[1:25]};
    assign lfsr_q = force_zero ? '0 : lfsr_reg;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            cyc();
            n++;
        end
    endtask

    function automatic logic [1:0] rr_model(input logic [1:0] r, input int last);
        return (r == 2'b11) ? ((last == 0) ? 2'b10 : 2'b01) : r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[17];
        logic [1:26] q;
        logic [25:0] w[6];
        logic [1:0]  e, r;
        int          n, loads, dup, last_g;
        logic [1:0]  gseen;
        tbl = '{'{2'b11, 2'b01}, '{2'b11, 2'b10}, '{2'b11, 2'b01}, '{2'b11, 2'b10},
                '{2'b11, 2'b01}, '{2'b11, 2'b10}, '{2'b10, 2'b10}, '{2'b10, 2'b10},
                '{2'b10, 2'b10}, '{2'b10, 2'b10}, '{2'b01, 2'b01}, '{2'b11, 2'b10},
                '{2'b11, 2'b01}, '{2'b00, 2'b00}, '{2'b01, 2'b01}, '{2'b10, 2'b10},
                '{2'b11, 2'b01}};
        @(negedge clk);
        repeat (3) cyc();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_zero_cnt", 32'(zero_cnt), 0);
        chk("rst_load", 32'(lfsr_load), 0);
        chk("rst_din", 32'(lfsr_din), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_lfsr_rst_n", 32'(lfsr_rst_n), 0);
        rst = 1'b0;
        n = 0;
        while (!lfsr_load && n < 5) begin
            cyc();
            n++;
        end
        chk("first_load_cycle", 32'(n), 1);
        chk("first_load_din", 32'(lfsr_din), 32'h1);
        n = 0; loads = 0; gseen = 2'b00;
        while (!ready && n < 20) begin
            cyc();
            n++;
            loads += int'(lfsr_load);
            gseen |= gnt;
        end
        chk("first_ready_latency", 32'(n), 9);
        chk("load_one_cycle", 32'(loads), 0);
        chk("no_gnt_warmup", 32'(gseen), 0);
        last_g = 1;
        for (int i = 0; i < 17; i++) begin
            req = tbl[i].req;
            q = lfsr_q;
            cyc();
            chk($sformatf("tbl_gnt_%0d", i), 32'(gnt), 32'(tbl[i].gnt));
            if (tbl[i].gnt != 2'b00) begin
                chk($sformatf("tbl_rdata_%0d", i), 32'(rdata), 32'(q));
                last_g = tbl[i].gnt[1] ? 1 : 0;
            end
            if (i < 6) w[i] = rdata;
        end
        dup = 0;
        for (int i = 0; i < 6; i++)
            for (int j = i + 1; j < 6; j++)
                dup += int'(w[i] == w[j]);
        chk("rdata_distinct", 32'(dup), 0);
        for (int i = 0; i < 150; i++) begin
            r = 2'($urandom_range(0, 3));
            req = r;
            q = lfsr_q;
            cyc();
            e = rr_model(r, last_g);
            chk("rand_gnt", 32'(gnt), 32'(e));
            chk("rand_ready", 32'(ready), 1);
            if (e != 2'b00) begin
                chk("rand_rdata", 32'(rdata), 32'(q));
                last_g = e[1] ? 1 : 0;
            end
        end
        req = 2'b01; seed_val = 26'h2AAAAAA; seed_req = 1'b1;
        cyc();
        seed_req = 1'b0;
        chk("seed_no_gnt", 32'(gnt), 0);
        chk("seed_ready_drop", 32'(ready), 0);
        cyc();
        chk("seed_load", 32'(lfsr_load), 1);
        chk("seed_din", 32'(lfsr_din), 32'h2AAAAAA);
        n = 0;
        while (gnt == 2'b00 && n < 30) begin
            cyc();
            n++;
        end
        chk("seed_resume_latency", 32'(n), 9);
        chk("seed_resume_ready", 32'(ready), 1);
        req = 2'b00; seed_val = '0; seed_req = 1'b1;
        cyc();
        seed_req = 1'b0;
        cyc();
        chk("zero_seed_load", 32'(lfsr_load), 1);
        chk("zero_seed_din", 32'(lfsr_din), 32'h1);
        wait_ready(n);
        chk("zero_seed_ready", 32'(n), 9);
        seed_val = 26'h0000123; seed_req = 1'b1;
        cyc();
        seed_val = 26'h0000456;
        cyc();
        seed_req = 1'b0;
        chk("dbl_load_1", 32'(lfsr_load), 1);
        chk("dbl_din_1", 32'(lfsr_din), 32'h123);
        cyc();
        chk("dbl_load_2", 32'(lfsr_load), 1);
        chk("dbl_din_2", 32'(lfsr_din), 32'h456);
        cyc();
        chk("dbl_load_end", 32'(lfsr_load), 0);
        wait_ready(n);
        chk("dbl_ready", 32'(n), 8);
        req = 2'b11; force_zero = 1'b1;
        cyc();
        force_zero = 1'b0; req = 2'b00;
        chk("lock_no_gnt", 32'(gnt), 0);
        chk("lock_ready", 32'(ready), 0);
        chk("lock_zero_cnt", 32'(zero_cnt), 1);
        cyc();
        chk("lock_load", 32'(lfsr_load), 1);
        chk("lock_din", 32'(lfsr_din), 32'h1);
        wait_ready(n);
        chk("lock_ready_latency", 32'(n), 9);
        force_zero = 1'b1; seed_req = 1'b1; seed_val = 26'h00ABCDE;
        cyc();
        force_zero = 1'b0; seed_req = 1'b0;
        chk("both_zero_cnt", 32'(zero_cnt), 2);
        chk("both_ready", 32'(ready), 0);
        cyc();
        chk("both_load", 32'(lfsr_load), 1);
        chk("both_din", 32'(lfsr_din), 32'h0ABCDE);
        wait_ready(n);
        force_zero = 1'b1;
        repeat (900) cyc();
        chk("zero_cnt_sat", 32'(zero_cnt), 255);
        chk("sat_ready", 32'(ready), 0);
        force_zero = 1'b0;
        wait_ready(n);
        chk("sat_recover", 32'(ready), 1);
        req = 2'b11;
        cyc();
        cyc();
        chk("pre_rst_gnt", 32'(gnt != 2'b00), 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_ready", 32'(ready), 0);
        chk("mid_rst_zero_cnt", 32'(zero_cnt), 0);
        chk("mid_rst_rdata", 32'(rdata), 0);
        rst = 1'b0; req = 2'b00;
        cyc();
        chk("mid_rst_load", 32'(lfsr_load), 1);
        chk("mid_rst_din", 32'(lfsr_din), 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
